ldm_writeback_sequencer: RTL and testbench
==========================================

# ldm_writeback_sequencer

Multi-register load sequencer that drives the register-file write-back port for LDM-style instructions. It takes a register list and a base address, and fetches one word per listed register from data memory over a req/ack handshake. Each fetched word is written to its register through the write-back port (enable, destination, data). It sits between the memory stage and the 15-entry register file (R0–R14). The pipeline holds on `busy`.

## Interface
Parameters:
- `DATA_W`, 32, data and address width.
- `REG_AW`, 4, register index width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: launch request, sampled in IDLE only.
- `reg_list` in 15: bit i set means load Ri (R0–R14).
- `base_addr` in `DATA_W`: base address, word-aligned.
- `pre_inc` in 1: 1 = increment-before (first address is base+4); 0 = increment-after (first address is base).
- `busy` out 1: high from the cycle after an accepted `start` until the `done` cycle, inclusive.
- `done` out 1: one-cycle completion pulse.
- `final_addr` out `DATA_W`: base + 4·popcount(`reg_list`); valid at `done`, held until the next accepted `start`.
- `mem_req` out 1: memory read request.
- `mem_addr` out `DATA_W`: read address.
- `mem_ack` in 1: read complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in `DATA_W`: read data.
- `wb_en` out 1: write-back enable, one cycle per register.
- `wb_dest` out `REG_AW`: write-back destination index.
- `wb_data` out `DATA_W`: write-back data.

## Operation
- States: IDLE, REQ, WRITE, DONE.
- **IDLE**:
  - On `start`=1: latch `reg_list` into the pending mask and compute `final_addr`.
  - Set the address counter to base+4 if `pre_inc`=1, otherwise base.
  - Next state is REQ if the mask is nonzero, DONE if it is zero.
- **REQ**:
  - `mem_req`=1 and `mem_addr` = address counter; both held stable until `mem_ack`.
  - On a rising edge with `mem_ack`=1:
    - register `mem_rdata` into `wb_data`;
    - set `wb_dest` to the lowest set index of the pending mask;
    - clear that bit;
    - add 4 to the address counter;
    - go to WRITE.
- **WRITE**:
  - `wb_en`=1 for exactly this cycle; `wb_dest` and `wb_data` stable for the whole cycle.
  - Next state is REQ if the mask is nonzero, DONE otherwise.
- **DONE**: `done`=1 for one cycle, then IDLE.
- Order: registers are loaded in ascending index order, at consecutive ascending word addresses.
- `start` is ignored in every state other than IDLE.
- `reg_list` and `base_addr` are only sampled on an accepted `start`.
- Address arithmetic wraps modulo 2^`DATA_W`; there is no alignment checking.
- `mem_ack` outside REQ is ignored.

## Timing
- Reset values (asynchronous, applied immediately):
  - state IDLE;
  - `busy`, `done`, `mem_req`, `wb_en` = 0;
  - `mem_addr`, `wb_dest`, `wb_data`, `final_addr`, mask, counter = 0.
- All outputs are registered; none depends combinationally on any input.
- The register file captures write-back on the falling clock edge. `wb_en`, `wb_dest` and `wb_data` change only on rising edges, which guarantees half a cycle of setup.
- Zero-wait memory: 2 cycles per register (REQ, WRITE), plus 1 for DONE.
  - N registers: `done` asserts 2N+1 cycles after the `start` edge.
  - Empty list: `done` asserts 1 cycle after the `start` edge.
- Each wait cycle (REQ with `mem_ack`=0) adds one cycle.
- At most one `wb_en` per register; never two in consecutive cycles.
- Reset mid-operation abandons the sequence. No further `wb_en` is issued, `mem_req` drops immediately, and the memory side must tolerate the abandoned request.
- `start` asserted in the `done` cycle is ignored. It is accepted on the following edge only if it is still held.

## Configuration
- Macro: `LDM_MEM_ERR_EN`.
- Defined:
  - Adds input `mem_err` (1 bit), qualified by `mem_ack`, and output `err` (1 bit).
  - An ack with `mem_err`=1 issues no `wb_en` for that register and goes straight to DONE.
  - `err`=1 in that DONE cycle only.
  - `final_addr` is still base + 4·popcount.
- Not defined: neither port exists; every ack is treated as good data.

## Test plan
- Reset, then idle 5 cycles: all outputs are 0.
- `reg_list`=0x0005, `base_addr`=0x100, `pre_inc`=0, immediate ack with data 0xA, 0xB:
  - R0←0xA, R2←0xB via reads at 0x100 and 0x104;
  - `done` at cycle 5; `final_addr`=0x108.
- `reg_list`=0x4000, base 0x200, `pre_inc`=1, ack delayed 3 cycles:
  - `mem_addr`=0x204 held for 4 cycles;
  - single `wb_en` with `wb_dest`=14.
- `reg_list`=0: `done` 1 cycle after `start`; no `mem_req`, no `wb_en`; `final_addr`=base.
- `rst` pulsed during the second REQ of 0x7FFF: `mem_req` and `wb_en` drop immediately; no writes after the first.
- With `LDM_MEM_ERR_EN`, list 0x0003, `mem_err` on the second ack:
  - only R0 is written;
  - `err`=1 together with `done`.

Source files
------------

// File: rtl/ldm_writeback_sequencer.sv
// LDM write-back sequencer: fetches one word per listed register over req/ack and writes it back.
// Optional build macro LDM_MEM_ERR_EN adds mem_err/err for aborting on a failed read.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_REQ   | read request outstanding at addr_q
// S_WRITE | wb_en pulse for the fetched word
// S_DONE  | one-cycle done pulse
module ldm_writeback_sequencer #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [14:0]       reg_list,
  input  logic [DATA_W-1:0] base_addr,
  input  logic              pre_inc,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] final_addr,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef LDM_MEM_ERR_EN
  input  logic              mem_err,
  output logic              err,
`endif
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_dest,
  output logic [DATA_W-1:0] wb_data
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE, S_DONE} state_t;

  state_t              state_q;
  logic [14:0]         mask_q;
  logic [DATA_W-1:0]   addr_q;
  logic [DATA_W-1:0]   final_addr_q;
  logic [DATA_W-1:0]   wb_data_q;
  logic [REG_AW-1:0]   wb_dest_q;
  logic                busy_q, done_q, mem_req_q, wb_en_q;
  logic                err_q;

  logic [4:0]          popcnt_d;
  logic [REG_AW-1:0]   lowest_d;
  logic [14:0]         mask_d;
  logic [DATA_W-1:0]   final_addr_d;
  logic [DATA_W-1:0]   first_addr_d;
  logic                ack_bad_d;

  always_comb begin
    popcnt_d = '0;
    lowest_d = '0;
    for (int i = 0; i < 15; i++) popcnt_d = popcnt_d + {4'b0, reg_list[i]};
    // Scan downward so the lowest set bit is the last one to win.
    for (int i = 14; i >= 0; i--) begin
      if (mask_q[i]) lowest_d = REG_AW'(i);
    end
    mask_d       = mask_q & ~(15'(1) << lowest_d);
    final_addr_d = base_addr + DATA_W'({popcnt_d, 2'b00});
    first_addr_d = pre_inc ? base_addr + DATA_W'(4) : base_addr;
`ifdef LDM_MEM_ERR_EN
    ack_bad_d    = mem_err;
`else
    ack_bad_d    = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      addr_q       <= '0;
      final_addr_q <= '0;
      wb_data_q    <= '0;
      wb_dest_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      wb_en_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mask_q       <= reg_list;
            final_addr_q <= final_addr_d;
            addr_q       <= first_addr_d;
            busy_q       <= 1'b1;
            if (reg_list != '0) begin
              state_q   <= S_REQ;
              mem_req_q <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            if (ack_bad_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              wb_data_q <= mem_rdata;
              wb_dest_q <= lowest_d;
              mask_q    <= mask_d;
              addr_q    <= addr_q + DATA_W'(4);
              wb_en_q   <= 1'b1;
              state_q   <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          wb_en_q <= 1'b0;
          if (mask_q != '0) begin
            state_q   <= S_REQ;
            mem_req_q <= 1'b1;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign final_addr = final_addr_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = addr_q;
  assign wb_en      = wb_en_q;
  assign wb_dest    = wb_dest_q;
  assign wb_data    = wb_data_q;
`ifdef LDM_MEM_ERR_EN
  assign err        = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_ldm_writeback_sequencer.sv
// Directed self-checking bench for ldm_writeback_sequencer; outputs sampled on the falling edge.
module tb_ldm_writeback_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [14:0] reg_list;
  logic [31:0] base_addr;
  logic        pre_inc;
  logic        busy, done;
  logic [31:0] final_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_data;
`ifdef LDM_MEM_ERR_EN
  logic        mem_err;
  logic        err;
`endif

  int checks = 0;
  int failures = 0;
  int wb_seen = 0;

  always #5 clk = ~clk;

  // Memory returns 0xA/0xB for the first directed case, otherwise a tag of the address.
  always_comb begin
    if (mem_addr == 32'h100)      mem_rdata = 32'hA;
    else if (mem_addr == 32'h104) mem_rdata = 32'hB;
    else                          mem_rdata = {16'hDA7A, mem_addr[15:0]};
  end

  ldm_writeback_sequencer #(.DATA_W(32), .REG_AW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .reg_list(reg_list),
    .base_addr(base_addr), .pre_inc(pre_inc), .busy(busy), .done(done),
    .final_addr(final_addr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
`ifdef LDM_MEM_ERR_EN
    .mem_err(mem_err), .err(err),
`endif
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data)
  );

  always @(negedge clk) if (wb_en) wb_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  int wb_before;

  initial begin
    rst = 1'b1; start = 1'b0; reg_list = '0; base_addr = '0; pre_inc = 1'b0; mem_ack = 1'b0;
`ifdef LDM_MEM_ERR_EN
    mem_err = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;

    // Idle after reset: everything quiet.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_busy", {31'b0, busy}, 32'd0);
      check("idle_done", {31'b0, done}, 32'd0);
      check("idle_req",  {31'b0, mem_req}, 32'd0);
      check("idle_wb",   {31'b0, wb_en}, 32'd0);
    end
    check("rst_final", final_addr, 32'd0);
    check("rst_addr",  mem_addr, 32'd0);
    check("rst_dest",  {28'b0, wb_dest}, 32'd0);
    check("rst_data",  wb_data, 32'd0);

    // R0, R2 from 0x100/0x104, zero-wait memory.
    reg_list = 15'h0005; base_addr = 32'h100; pre_inc = 1'b0; start = 1'b1; mem_ack = 1'b1;
    tick(); start = 1'b0;
    check("t2_c1_req",  {31'b0, mem_req}, 32'd1);
    check("t2_c1_addr", mem_addr, 32'h100);
    check("t2_c1_busy", {31'b0, busy}, 32'd1);
    tick();
    check("t2_c2_wb",   {31'b0, wb_en}, 32'd1);
    check("t2_c2_dest", {28'b0, wb_dest}, 32'd0);
    check("t2_c2_data", wb_data, 32'hA);
    check("t2_c2_req",  {31'b0, mem_req}, 32'd0);
    tick();
    check("t2_c3_wb",   {31'b0, wb_en}, 32'd0);
    check("t2_c3_addr", mem_addr, 32'h104);
    check("t2_c3_req",  {31'b0, mem_req}, 32'd1);
    tick();
    check("t2_c4_wb",   {31'b0, wb_en}, 32'd1);
    check("t2_c4_dest", {28'b0, wb_dest}, 32'd2);
    check("t2_c4_data", wb_data, 32'hB);
    tick();
    check("t2_c5_done", {31'b0, done}, 32'd1);
    check("t2_c5_busy", {31'b0, busy}, 32'd1);
    check("t2_c5_wb",   {31'b0, wb_en}, 32'd0);
    check("t2_final",   final_addr, 32'h108);
    tick();
    mem_ack = 1'b0;
    check("t2_c6_done", {31'b0, done}, 32'd0);
    check("t2_c6_busy", {31'b0, busy}, 32'd0);
    check("t2_hold",    final_addr, 32'h108);

    // R14 with pre-increment, ack three cycles late.
    reg_list = 15'h4000; base_addr = 32'h200; pre_inc = 1'b1; start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick(); start = 1'b0;
      check("t3_req_held",  {31'b0, mem_req}, 32'd1);
      check("t3_addr_held", mem_addr, 32'h204);
      check("t3_no_wb",     {31'b0, wb_en}, 32'd0);
    end
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    check("t3_wb",   {31'b0, wb_en}, 32'd1);
    check("t3_dest", {28'b0, wb_dest}, 32'd14);
    check("t3_data", wb_data, 32'hDA7A0204);
    tick();
    check("t3_done",  {31'b0, done}, 32'd1);
    check("t3_wb_off", {31'b0, wb_en}, 32'd0);
    check("t3_final", final_addr, 32'h204);
    tick();

    // Empty list; start held through done must not retrigger until IDLE.
    wb_before = wb_seen;
    reg_list = 15'h0000; base_addr = 32'h300; pre_inc = 1'b0; start = 1'b1;
    tick();
    check("t4_done",  {31'b0, done}, 32'd1);
    check("t4_busy",  {31'b0, busy}, 32'd1);
    check("t4_req",   {31'b0, mem_req}, 32'd0);
    check("t4_final", final_addr, 32'h300);
    tick();
    check("t4_ign_done", {31'b0, done}, 32'd0);
    check("t4_ign_busy", {31'b0, busy}, 32'd0);
    tick(); start = 1'b0;
    check("t4_re_done", {31'b0, done}, 32'd1);
    tick();
    check("t4_idle", {31'b0, busy}, 32'd0);
    check("t4_no_wb", wb_seen - wb_before, 32'd0);

    // Reset during second REQ of a 15-register load.
    wb_before = wb_seen;
    reg_list = 15'h7FFF; base_addr = 32'h400; pre_inc = 1'b0; start = 1'b1; mem_ack = 1'b1;
    tick(); start = 1'b0;
    tick();
    check("t5_first_wb", {31'b0, wb_en}, 32'd1);
    tick();
    check("t5_req2", {31'b0, mem_req}, 32'd1);
    check("t5_addr2", mem_addr, 32'h404);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_req",  {31'b0, mem_req}, 32'd0);
    check("t5_rst_wb",   {31'b0, wb_en}, 32'd0);
    check("t5_rst_busy", {31'b0, busy}, 32'd0);
    tick(); rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t5_after_req", {31'b0, mem_req}, 32'd0);
    end
    mem_ack = 1'b0;
    check("t5_wb_count", wb_seen - wb_before, 32'd1);

`ifdef LDM_MEM_ERR_EN
    // Error on second ack: only R0 written, err with done.
    wb_before = wb_seen;
    reg_list = 15'h0003; base_addr = 32'h500; pre_inc = 1'b0; start = 1'b1; mem_ack = 1'b1;
    tick(); start = 1'b0;
    tick();
    check("t6_wb0", {28'b0, wb_dest}, 32'd0);
    tick(); mem_err = 1'b1;
    tick(); mem_err = 1'b0; mem_ack = 1'b0;
    check("t6_done",  {31'b0, done}, 32'd1);
    check("t6_err",   {31'b0, err}, 32'd1);
    check("t6_no_wb", {31'b0, wb_en}, 32'd0);
    check("t6_final", final_addr, 32'h508);
    tick();
    check("t6_err_off", {31'b0, err}, 32'd0);
    check("t6_wb_count", wb_seen - wb_before, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
